// File: rtl/writeback_stage_pkg.sv
// Shared core constants for the writeback stage.
// Result-source selector codes, load funct3 codes, datapath width.
package writeback_stage_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] RESULT_SRC_ALU  = 2'd0;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'd1;
  localparam logic [1:0] RESULT_SRC_PC4  = 2'd2;
  localparam logic [1:0] RESULT_SRC_IMM  = 2'd3;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

endpackage

// File: rtl/mux4.sv
// Generic 4-way multiplexer.
// Shared utility reused for result selection.
module mux4 #(
  parameter int W = 32
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/writeback_stage_load_extend.sv
// RV32 load-data alignment and sign/zero extension.
// Byte/halfword picked from the memory word by address offset.
module load_extend
  import writeback_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data[7:0];
    case (offset)
      2'd0:    byte_sel = data[7:0];
      2'd1:    byte_sel = data[15:8];
      2'd2:    byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase
  end

  // halfword ignores offset[0]: misaligned halves are not split
  assign half_sel = offset[1] ? data[31:16] : data[15:0];

  always_comb begin
    value = data;
    case (funct3)
      LOAD_LB:  value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LOAD_LBU: value = {{(XLEN-8){1'b0}}, byte_sel};
      LOAD_LH:  value = {{(XLEN-16){half_sel[15]}}, half_sel};
      LOAD_LHU: value = {{(XLEN-16){1'b0}}, half_sel};
      LOAD_LW:  value = data;
      default:  value = data;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Register-writeback stage: source select, load extension,
// registered result toward the register file, retire counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidW,
  input  logic             RegWriteW,
  input  logic [SRC_W-1:0] ResultSrcW,
  input  logic [2:0]       LoadFuncW,
  input  logic [XLEN-1:0]  ReadDataW,
  input  logic [XLEN-1:0]  ALUResultW,
  input  logic [XLEN-1:0]  PCPlus4W,
  input  logic [XLEN-1:0]  ImmExtW,
  input  logic [4:0]       RdW,
  input  logic             StallW,
  input  logic             FlushW,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  output logic [XLEN-1:0]  Result,
  output logic             RegWrite,
  output logic [4:0]       Rd,
  output logic             Valid,
  output logic [CNT_W-1:0] InstRet,
  output logic             FwdMatch1,
  output logic             FwdMatch2
);

  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] mux_val;
  logic [XLEN-1:0] sel_val;
  logic            src_ok;
  logic            write_en;

  load_extend #(.XLEN(XLEN)) u_ext (
    .funct3(LoadFuncW),
    .offset(ALUResultW[1:0]),
    .data  (ReadDataW),
    .value (load_val)
  );

  mux4 #(.W(XLEN)) u_mux (
    .sel(ResultSrcW[1:0]),
    .d0 (ALUResultW),
    .d1 (load_val),
    .d2 (PCPlus4W),
    .d3 (ImmExtW),
    .y  (mux_val)
  );

  // unpopulated selector codes read as zero
  assign src_ok   = int'(ResultSrcW) < NUM_SRC;
  assign sel_val  = src_ok ? mux_val : '0;
  assign write_en = RegWriteW & ValidW & (RdW != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      Result   <= '0;
      RegWrite <= 1'b0;
      Rd       <= 5'd0;
      Valid    <= 1'b0;
      InstRet  <= '0;
    end else if (FlushW) begin
      Result   <= '0;
      RegWrite <= 1'b0;
      Rd       <= 5'd0;
      Valid    <= 1'b0;
    end else if (!StallW) begin
      Result   <= sel_val;
      RegWrite <= write_en;
      Rd       <= RdW;
      Valid    <= ValidW;
      if (ValidW)
        InstRet <= InstRet + CNT_W'(1);
    end
  end

  assign FwdMatch1 = RegWrite && (Rd == Rs1D);
  assign FwdMatch2 = RegWrite && (Rd == Rs2D);

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
// Second instance uses NUM_SRC=3, CNT_W=4 for selector and wrap cases.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidW, RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [2:0]  LoadFuncW;
  logic [31:0] ReadDataW, ALUResultW, PCPlus4W, ImmExtW;
  logic [4:0]  RdW, Rs1D, Rs2D;
  logic        StallW, FlushW;

  logic [31:0] res;
  logic        rw, vld, fm1, fm2;
  logic [4:0]  rd;
  logic [63:0] iret;

  logic [31:0] res3;
  logic        rw3, vld3, fm13, fm23;
  logic [4:0]  rd3;
  logic [3:0]  iret3;

  int checks = 0;
  int failures = 0;
  longint cnt = 0;

  writeback_stage dut (
    .clk(clk), .rst(rst), .ValidW(ValidW), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .LoadFuncW(LoadFuncW),
    .ReadDataW(ReadDataW), .ALUResultW(ALUResultW),
    .PCPlus4W(PCPlus4W), .ImmExtW(ImmExtW), .RdW(RdW),
    .StallW(StallW), .FlushW(FlushW), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .Result(res), .RegWrite(rw), .Rd(rd), .Valid(vld),
    .InstRet(iret), .FwdMatch1(fm1), .FwdMatch2(fm2)
  );

  writeback_stage #(.NUM_SRC(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .ValidW(ValidW), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .LoadFuncW(LoadFuncW),
    .ReadDataW(ReadDataW), .ALUResultW(ALUResultW),
    .PCPlus4W(PCPlus4W), .ImmExtW(ImmExtW), .RdW(RdW),
    .StallW(StallW), .FlushW(FlushW), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .Result(res3), .RegWrite(rw3), .Rd(rd3), .Valid(vld3),
    .InstRet(iret3), .FwdMatch1(fm13), .FwdMatch2(fm23)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; StallW = 0; FlushW = 0;
    ValidW = 1; RegWriteW = 1; ResultSrcW = 2'd0; LoadFuncW = 3'b010;
    ReadDataW = 32'h0; ALUResultW = 32'h0000_1234;
    PCPlus4W = 32'h0; ImmExtW = 32'h0; RdW = 5'd5;
    Rs1D = 5'd5; Rs2D = 5'd6;
    tick; tick;
    checks++;
    if (res !== 32'h0 || rw !== 1'b0 || rd !== 5'd0 || vld !== 1'b0) begin
      failures++;
      $display("FAIL reset_outs got res=%h rw=%b rd=%0d v=%b exp all 0", res, rw, rd, vld);
    end
    checks++;
    if (iret !== 64'd0 || iret3 !== 4'd0) begin
      failures++;
      $display("FAIL reset_instret got %0d/%0d exp 0", iret, iret3);
    end
    checks++;
    if (fm1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_fwd got %b exp 0", fm1);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu;
    tick; cnt++;
    checks++;
    if (res !== 32'h0000_1234 || rd !== 5'd5 || rw !== 1'b1 || vld !== 1'b1) begin
      failures++;
      $display("FAIL alu_wb got res=%h rd=%0d rw=%b v=%b exp 1234/5/1/1", res, rd, rw, vld);
    end
    checks++;
    if (iret !== 64'd1) begin
      failures++;
      $display("FAIL alu_instret got %0d exp 1", iret);
    end
    checks++;
    if (fm1 !== 1'b1 || fm2 !== 1'b0) begin
      failures++;
      $display("FAIL alu_fwd got %b%b exp 10", fm1, fm2);
    end
    Rs2D = 5'd5; #1;
    checks++;
    if (fm2 !== 1'b1) begin
      failures++;
      $display("FAIL fwd2 got %b exp 1", fm2);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
    logic [1:0]  o [6] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [31:0] e [6] = '{32'hFFFF_FF81, 32'h0000_0080, 32'hFFFF_80F0,
                           32'h0000_7F81, 32'h80F0_7F81, 32'h80F0_7F81};
    ResultSrcW = 2'd1; ReadDataW = 32'h80F0_7F81; RdW = 5'd10;
    for (int i = 0; i < 6; i++) begin
      LoadFuncW = f[i];
      ALUResultW = {30'h100, o[i]};
      tick; cnt++;
      checks++;
      if (res !== e[i]) begin
        failures++;
        $display("FAIL load_%0d f3=%b off=%0d got %h exp %h", i, f[i], o[i], res, e[i]);
      end
    end
    checks++;
    if (iret !== 64'(cnt)) begin
      failures++;
      $display("FAIL load_instret got %0d exp %0d", iret, cnt);
    end
  endtask

  task automatic test_select;
    ResultSrcW = 2'd2; PCPlus4W = 32'h0000_0104; ImmExtW = 32'hABCD_E000;
    tick; cnt++;
    checks++;
    if (res !== 32'h0000_0104 || res3 !== 32'h0000_0104) begin
      failures++;
      $display("FAIL sel_pc4 got %h/%h exp 00000104", res, res3);
    end
    ResultSrcW = 2'd3;
    tick; cnt++;
    checks++;
    if (res !== 32'hABCD_E000) begin
      failures++;
      $display("FAIL sel_imm got %h exp abcde000", res);
    end
    checks++;
    if (res3 !== 32'h0) begin
      failures++;
      $display("FAIL sel_oob got %h exp 0", res3);
    end
  endtask

  task automatic test_x0;
    ResultSrcW = 2'd0; ALUResultW = 32'h55; RdW = 5'd0; RegWriteW = 1;
    Rs1D = 5'd0;
    tick; cnt++;
    checks++;
    if (rw !== 1'b0 || vld !== 1'b1 || iret !== 64'(cnt)) begin
      failures++;
      $display("FAIL x0 got rw=%b v=%b ir=%0d exp 0/1/%0d", rw, vld, iret, cnt);
    end
    checks++;
    if (fm1 !== 1'b0) begin
      failures++;
      $display("FAIL x0_fwd got %b exp 0", fm1);
    end
    ValidW = 0; RdW = 5'd3;
    tick;
    checks++;
    if (rw !== 1'b0 || vld !== 1'b0 || iret !== 64'(cnt)) begin
      failures++;
      $display("FAIL invalid got rw=%b v=%b ir=%0d exp 0/0/%0d", rw, vld, iret, cnt);
    end
    checks++;
    if (iret3 !== 4'(cnt)) begin
      failures++;
      $display("FAIL cnt4 got %0d exp %0d", iret3, 4'(cnt));
    end
    ValidW = 1;
  endtask

  task automatic test_stall_flush;
    ALUResultW = 32'hAAAA_0000; RdW = 5'd7; RegWriteW = 1;
    tick; cnt++;
    checks++;
    if (res !== 32'hAAAA_0000 || rd !== 5'd7) begin
      failures++;
      $display("FAIL pre_stall got %h/%0d exp aaaa0000/7", res, rd);
    end
    StallW = 1;
    for (int i = 0; i < 3; i++) begin
      ALUResultW = 32'(i + 1); RdW = 5'd9;
      tick;
      checks++;
      if (res !== 32'hAAAA_0000 || rd !== 5'd7 || rw !== 1'b1
          || vld !== 1'b1 || iret !== 64'(cnt)) begin
        failures++;
        $display("FAIL stall_%0d got %h/%0d/%b/%b/%0d exp aaaa0000/7/1/1/%0d",
                 i, res, rd, rw, vld, iret, cnt);
      end
    end
    FlushW = 1;
    tick;
    checks++;
    if (vld !== 1'b0 || rw !== 1'b0 || rd !== 5'd0 || res !== 32'h0) begin
      failures++;
      $display("FAIL flush got v=%b rw=%b rd=%0d res=%h exp 0", vld, rw, rd, res);
    end
    checks++;
    if (iret !== 64'(cnt)) begin
      failures++;
      $display("FAIL flush_instret got %0d exp %0d", iret, cnt);
    end
    FlushW = 0; StallW = 0;
  endtask

  task automatic test_wrap;
    rst = 1; tick; rst = 0; cnt = 0;
    ValidW = 1; ResultSrcW = 2'd0; RdW = 5'd4;
    for (int i = 0; i < 17; i++) begin
      ALUResultW = 32'(i);
      tick; cnt++;
    end
    checks++;
    if (iret3 !== 4'd1) begin
      failures++;
      $display("FAIL wrap got %0d exp 1", iret3);
    end
    checks++;
    if (iret !== 64'd17) begin
      failures++;
      $display("FAIL count17 got %0d exp 17", iret);
    end
    StallW = 1; tick;
    rst = 1; tick;
    checks++;
    if (iret !== 64'd0 || iret3 !== 4'd0 || vld !== 1'b0 || res !== 32'h0) begin
      failures++;
      $display("FAIL rst_in_stall got ir=%0d/%0d v=%b res=%h exp 0", iret, iret3, vld, res);
    end
    rst = 0; StallW = 0;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_loads;
    test_select;
    test_x0;
    test_stall_flush;
    test_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Parametrised next-generation register-writeback stage for the RISC-V pipeline core.
- Selects the result from up to four sources.
- Performs RV32 load-data extraction: byte/halfword alignment and sign/zero extension.
- Registers the result, destination and write-enable toward the register file.
- Supports stall and flush, keeps a retired-instruction counter, and exposes combinational forwarding-match flags for the decode stage.
- Sits between the memory stage pipeline register and the register file / hazard unit.

Parameters:
XLEN, 32, datapath width (supported: 32).
NUM_SRC, 4, number of active result sources (2..4); selector codes >= NUM_SRC yield zero.
SRC_W, 2, ResultSrcW width; must satisfy 2^SRC_W >= NUM_SRC.
CNT_W, 64, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising-edge.
rst  in  1  reset, synchronous, active-high.
ValidW  in  1  memory-stage instruction valid.
RegWriteW  in  1  instruction writes rd.
ResultSrcW  in  SRC_W  0=ALU, 1=load, 2=PC+4, 3=immediate (LUI).
LoadFuncW  in  3  load funct3.
ReadDataW  in  XLEN  raw aligned word from data memory.
ALUResultW  in  XLEN  ALU result / load address.
PCPlus4W  in  XLEN  PC+4.
ImmExtW  in  XLEN  extended immediate.
RdW  in  5  destination register.
StallW  in  1  hold stage.
FlushW  in  1  squash incoming instruction.
Rs1D  in  5  decode-stage source 1.
Rs2D  in  5  decode-stage source 2.
Result  out  XLEN  registered writeback data.
RegWrite  out  1  registered register-file write enable.
Rd  out  5  registered destination.
Valid  out  1  registered valid.
InstRet  out  CNT_W  retired-instruction count.
FwdMatch1  out  1  RegWrite && Rd == Rs1D.
FwdMatch2  out  1  RegWrite && Rd == Rs2D.

Behaviour:
- Reset, synchronous: on any rising edge with rst=1, all registered outputs clear to 0, including InstRet. Reset overrides stall and flush.
- Latency: exactly one cycle from W inputs to Result/RegWrite/Rd/Valid. FwdMatch1/2 are combinational from the registered outputs and Rs1D/Rs2D.
- Load extraction uses offset = ALUResultW[1:0]:
  - 000 LB: byte at offset, sign-extended.
  - 100 LBU: byte at offset, zero-extended.
  - 001 LH: halfword at offset[1], sign-extended; offset[0] is ignored.
  - 101 LHU: halfword at offset[1], zero-extended; offset[0] is ignored.
  - 010 LW: full word; offset is ignored.
  - Other funct3 codes: raw ReadDataW.
- Select: source 0/1/2/3 per ResultSrcW; code >= NUM_SRC gives 0.
- Per-cycle priority, highest first: rst > FlushW > StallW > normal.
  - FlushW=1: Valid=0, RegWrite=0, Rd=0, Result=0; InstRet unchanged.
  - StallW=1, no flush: all registered outputs and InstRet hold.
  - Normal: Result <= selected value; Rd <= RdW; Valid <= ValidW; RegWrite <= RegWriteW & ValidW & (RdW != 0).
- x0 suppression: RdW=0 never asserts RegWrite, but the instruction still counts as retired.
- InstRet increments by 1 on each normal-advance cycle with ValidW=1. It wraps modulo 2^CNT_W with no saturation and no flag.
- No ready/valid backpressure is generated; stall is externally driven by the hazard unit.

Decomposition:
- Shared core package holds:
  - RESULT_SRC_* selector constants (ALU=0, LOAD=1, PC4=2, IMM=3).
  - LOAD funct3 constants (LB, LH, LW, LBU, LHU).
  - XLEN default.
- One natural sub-module: load_extend, the combinational alignment and sign/zero extension of the load word from funct3 and offset.
- The existing mux4 is reused for source selection.

Test Plan:
- Reset: hold rst=1 for 2 cycles with active inputs -> all outputs 0, InstRet=0; outputs update on the first cycle after rst falls.
- ALU writeback: ValidW=1, RegWriteW=1, ResultSrcW=0, ALUResultW=0x0000_1234, RdW=5 -> next cycle Result=0x1234, Rd=5, RegWrite=1, InstRet=1; Rs1D=5 -> FwdMatch1=1.
- Loads with ReadDataW=0x80F0_7F81, load source selected:
  - LB offset 0 -> 0xFFFF_FF81.
  - LBU offset 3 -> 0x0000_0080.
  - LH offset 2 -> 0xFFFF_80F0.
  - LHU offset 0 -> 0x0000_7F81.
  - LW offset 1 -> 0x80F0_7F81.
- x0 and selector edge cases: RdW=0, RegWriteW=1 -> RegWrite=0, Valid=1, InstRet increments. With NUM_SRC=3, ResultSrcW=3 -> Result=0.
- Stall/flush: StallW=1 for 3 cycles while inputs change -> outputs and InstRet frozen. FlushW=1 together with StallW=1 -> next cycle Valid=0, RegWrite=0, InstRet unchanged.
- Counter wrap: CNT_W=4, retire 17 valid instructions -> InstRet=1. Assert rst mid-stall -> InstRet=0 on the next edge.
